axil_rd_arbiter: RTL and testbench



---
 rtl/axil_rd_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axil_rd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master between two requesters,
// one transaction in flight, with a response watchdog that drains late beats.
module axil_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
   input  logic [2:0]            s0_axil_arprot,
   input  logic                  s0_axil_arvalid,
   output logic                  s0_axil_arready,
   output logic [DATA_WIDTH-1:0] s0_axil_rdata,
   output logic [1:0]            s0_axil_rresp,
   output logic                  s0_axil_rvalid,
   input  logic                  s0_axil_rready,

   input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
   input  logic [2:0]            s1_axil_arprot,
   input  logic                  s1_axil_arvalid,
   output logic                  s1_axil_arready,
   output logic [DATA_WIDTH-1:0] s1_axil_rdata,
   output logic [1:0]            s1_axil_rresp,
   output logic                  s1_axil_rvalid,
   input  logic                  s1_axil_rready,

   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam int               CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit               WDOG_EN     = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST    = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [1:0]       RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN} state_t;

   state_t                state_reg, state_next;
   logic                  last_reg;
   logic                  grant_reg;
   logic                  timed_out_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [ADDR_WIDTH-1:0] araddr_reg;
   logic [2:0]            arprot_reg;

   logic [1:0]            arvalid_vec;
   logic [1:0]            rready_vec;
   logic [1:0]            rvalid_vec;
   logic [1:0]            ar_win;
   logic                  data_hit;
   logic                  data_timeout;

   logic [ADDR_WIDTH-1:0] araddr_arr [2];
   logic [2:0]            arprot_arr [2];
   logic [DATA_WIDTH-1:0] rdata_arr  [2];
   logic [1:0]            rresp_arr  [2];

   assign arvalid_vec   = {s1_axil_arvalid, s0_axil_arvalid};
   assign rready_vec    = {s1_axil_rready, s0_axil_rready};
   assign araddr_arr[0] = s0_axil_araddr;
   assign araddr_arr[1] = s1_axil_araddr;
   assign arprot_arr[0] = s0_axil_arprot;
   assign arprot_arr[1] = s1_axil_arprot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Grant is decided only in IDLE; a tie goes to the port that did not win last.
   always_comb begin
      state_next   = state_reg;
      ar_win       = 2'b00;
      data_hit     = 1'b0;
      data_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arvalid_vec[0] && (!arvalid_vec[1] || last_reg)) begin
               ar_win = 2'b01;
            end else if (arvalid_vec[1]) begin
               ar_win = 2'b10;
            end
            if (ar_win != 2'b00) begin
               state_next = ADDR;
            end
         end
         ADDR: begin
            if (m_axil_arready) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (m_axil_rvalid) begin
               data_hit   = 1'b1;
               state_next = RESP;
            end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
               data_timeout = 1'b1;
               state_next   = RESP;
            end
         end
         RESP: begin
            if (rready_vec[grant_reg]) begin
               state_next = timed_out_reg ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (m_axil_rvalid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg      <= 1'b1;
         grant_reg     <= 1'b0;
         timed_out_reg <= 1'b0;
         cnt_reg       <= '0;
         araddr_reg    <= '0;
         arprot_reg    <= '0;
      end else begin
         if (ar_win != 2'b00) begin
            grant_reg  <= ar_win[1];
            last_reg   <= ar_win[1];
            araddr_reg <= araddr_arr[ar_win[1]];
            arprot_reg <= arprot_arr[ar_win[1]];
         end
         // Saturating so a stuck slave with the watchdog disabled never wraps.
         if (state_reg == ADDR && m_axil_arready) begin
            cnt_reg <= '0;
         end else if (state_reg == DATA && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (data_timeout) begin
            timed_out_reg <= 1'b1;
         end else if (state_reg == DRAIN && m_axil_rvalid) begin
            timed_out_reg <= 1'b0;
         end
      end
   end

   // Response registers are per port so the idle requester never sees foreign data.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_WIDTH-1:0] rdata_reg;
         logic [1:0]            rresp_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_reg <= '0;
               rresp_reg <= 2'b00;
            end else if ((data_hit || data_timeout) && (grant_reg == 1'(gi))) begin
               rdata_reg <= data_hit ? m_axil_rdata : '0;
               rresp_reg <= data_hit ? m_axil_rresp : RESP_SLVERR;
            end
         end

         assign rdata_arr[gi]  = rdata_reg;
         assign rresp_arr[gi]  = rresp_reg;
         assign rvalid_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
      end
   endgenerate

   assign s0_axil_arready = ar_win[0];
   assign s1_axil_arready = ar_win[1];
   assign s0_axil_rvalid  = rvalid_vec[0];
   assign s1_axil_rvalid  = rvalid_vec[1];
   assign s0_axil_rdata   = rdata_arr[0];
   assign s1_axil_rdata   = rdata_arr[1];
   assign s0_axil_rresp   = rresp_arr[0];
   assign s1_axil_rresp   = rresp_arr[1];

   assign m_axil_araddr   = araddr_reg;
   assign m_axil_arprot   = arprot_reg;
   assign m_axil_arvalid  = (state_reg == ADDR);
   assign m_axil_rready   = (state_reg == DATA) || (state_reg == DRAIN);

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Bench for axil_rd_arbiter: transaction-level round-robin/timeout model driving
// randomized requesters and a scripted slave, checked cycle by cycle.
module tb_axil_rd_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0][31:0] s_araddr;
   logic [1:0][2:0]  s_arprot;
   logic [1:0]       s_arvalid;
   logic [1:0]       s_rready;

   logic        s0_axil_arready, s1_axil_arready, s0_axil_rvalid, s1_axil_rvalid;
   logic [31:0] s0_axil_rdata, s1_axil_rdata;
   logic [1:0]  s0_axil_rresp, s1_axil_rresp;

   logic [31:0] m_axil_araddr, m_rdata;
   logic [2:0]  m_axil_arprot;
   logic        m_axil_arvalid, m_axil_rready, m_arready, m_rvalid;
   logic [1:0]  m_rresp;

   int   total = 0;
   int   bad   = 0;
   bit   model_last;
   bit [1:0] pend;

   always #5 clk = ~clk;

   axil_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .s0_axil_araddr  (s_araddr[0]),
      .s0_axil_arprot  (s_arprot[0]),
      .s0_axil_arvalid (s_arvalid[0]),
      .s0_axil_arready (s0_axil_arready),
      .s0_axil_rdata   (s0_axil_rdata),
      .s0_axil_rresp   (s0_axil_rresp),
      .s0_axil_rvalid  (s0_axil_rvalid),
      .s0_axil_rready  (s_rready[0]),
      .s1_axil_araddr  (s_araddr[1]),
      .s1_axil_arprot  (s_arprot[1]),
      .s1_axil_arvalid (s_arvalid[1]),
      .s1_axil_arready (s1_axil_arready),
      .s1_axil_rdata   (s1_axil_rdata),
      .s1_axil_rresp   (s1_axil_rresp),
      .s1_axil_rvalid  (s1_axil_rvalid),
      .s1_axil_rready  (s_rready[1]),
      .m_axil_araddr   (m_axil_araddr),
      .m_axil_arprot   (m_axil_arprot),
      .m_axil_arvalid  (m_axil_arvalid),
      .m_axil_arready  (m_arready),
      .m_axil_rdata    (m_rdata),
      .m_axil_rresp    (m_rresp),
      .m_axil_rvalid   (m_rvalid),
      .m_axil_rready   (m_axil_rready)
   );

   wire [1:0] ardy = {s1_axil_arready, s0_axil_arready};
   wire [1:0] rv   = {s1_axil_rvalid, s0_axil_rvalid};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic post(input int p);
      if (!pend[p]) begin
         pend[p]     = 1'b1;
         s_araddr[p] = $urandom & 32'hFFFF_FFFC;
         s_arprot[p] = 3'($urandom);
      end
   endtask

   // One complete transaction, entered at the start of an IDLE cycle.
   task automatic do_txn(input int ar_wait, input int r_wait, input int rr_wait,
                         input int drain_wait, input bit silent, input bit repost,
                         input logic [31:0] data, input logic [1:0] resp, output int got);
      int          w;
      logic [31:0] exp_addr, exp_data, rd;
      logic [2:0]  exp_prot;
      logic [1:0]  exp_resp, rs;
      s_arvalid = pend;
      if (pend == 2'b11) w = model_last ? 0 : 1;
      else               w = pend[1] ? 1 : 0;
      exp_addr = s_araddr[w];
      exp_prot = s_arprot[w];
      @(negedge clk);
      got = s1_axil_arready ? 1 : 0;
      total++;
      if (ardy !== 2'(1 << w))
         begin bad++; $display("FAIL grant: arready=%b want %b (pend=%b)", ardy, 2'(1 << w), pend); end
      tick();
      model_last   = w[0];
      pend[w]      = 1'b0;
      s_arvalid[w] = 1'b0;
      s_araddr[w]  = $urandom;
      if (repost) begin
         post(w);
         s_arvalid[w] = 1'b1;
      end
      for (int c = 0; c <= ar_wait; c++) begin
         m_arready = (c == ar_wait);
         @(negedge clk);
         total++;
         if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== exp_addr || m_axil_arprot !== exp_prot)
            begin bad++; $display("FAIL addr_phase: arvalid=%b araddr=%h arprot=%h want 1 %h %h",
                                  m_axil_arvalid, m_axil_araddr, m_axil_arprot, exp_addr, exp_prot); end
         total++;
         if (ardy !== 2'b00 || rv !== 2'b00 || m_axil_rready !== 1'b0)
            begin bad++; $display("FAIL addr_side: arready=%b rvalid=%b rready=%b want 00 00 0", ardy, rv, m_axil_rready); end
         tick();
      end
      m_arready = 1'b0;
      exp_data = silent ? 32'h0 : data;
      exp_resp = silent ? 2'b10 : resp;
      for (int c = 0; c < (silent ? TO : r_wait + 1); c++) begin
         m_rvalid = !silent && (c == r_wait);
         m_rdata  = m_rvalid ? data : $urandom;
         m_rresp  = m_rvalid ? resp : 2'($urandom);
         @(negedge clk);
         total++;
         if (m_axil_rready !== 1'b1 || m_axil_arvalid !== 1'b0 || rv !== 2'b00 || ardy !== 2'b00)
            begin bad++; $display("FAIL data_phase c=%0d: rready=%b arvalid=%b rvalid=%b arready=%b want 1 0 00 00",
                                  c, m_axil_rready, m_axil_arvalid, rv, ardy); end
         tick();
      end
      m_rvalid = 1'b0;
      for (int c = 0; c <= rr_wait; c++) begin
         s_rready[w]     = (c == rr_wait);
         s_rready[1 - w] = 1'b1;
         @(negedge clk);
         rd = (w == 1) ? s1_axil_rdata : s0_axil_rdata;
         rs = (w == 1) ? s1_axil_rresp : s0_axil_rresp;
         total++;
         if (rv !== 2'(1 << w) || rd !== exp_data || rs !== exp_resp)
            begin bad++; $display("FAIL resp c=%0d: rvalid=%b rdata=%h rresp=%b want %b %h %b",
                                  c, rv, rd, rs, 2'(1 << w), exp_data, exp_resp); end
         total++;
         if (ardy !== 2'b00 || m_axil_arvalid !== 1'b0 || m_axil_rready !== 1'b0)
            begin bad++; $display("FAIL resp_side: arready=%b arvalid=%b rready=%b want 00 0 0", ardy, m_axil_arvalid, m_axil_rready); end
         tick();
      end
      s_rready = 2'b00;
      if (silent) begin
         for (int c = 0; c <= drain_wait; c++) begin
            m_rvalid = (c == drain_wait);
            m_rdata  = $urandom;
            m_rresp  = 2'b00;
            @(negedge clk);
            total++;
            if (m_axil_rready !== 1'b1 || rv !== 2'b00 || ardy !== 2'b00 || m_axil_arvalid !== 1'b0)
               begin bad++; $display("FAIL drain c=%0d: rready=%b rvalid=%b arready=%b arvalid=%b want 1 00 00 0",
                                     c, m_axil_rready, rv, ardy, m_axil_arvalid); end
            tick();
         end
         m_rvalid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pend = 2'b00; s_arvalid = 2'b00; s_rready = 2'b00;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
      repeat (2) tick();
      @(negedge clk);
      total++;
      if (ardy !== 2'b00 || rv !== 2'b00 || m_axil_arvalid !== 1'b0 || m_axil_rready !== 1'b0)
         begin bad++; $display("FAIL reset_ctrl: arready=%b rvalid=%b arvalid=%b rready=%b want 0", ardy, rv, m_axil_arvalid, m_axil_rready); end
      total++;
      if (m_axil_araddr !== 32'h0 || m_axil_arprot !== 3'h0)
         begin bad++; $display("FAIL reset_addr: araddr=%h arprot=%h want 0", m_axil_araddr, m_axil_arprot); end
      total++;
      if (s0_axil_rdata !== 32'h0 || s1_axil_rdata !== 32'h0 || s0_axil_rresp !== 2'b00 || s1_axil_rresp !== 2'b00)
         begin bad++; $display("FAIL reset_data: rdata=%h/%h rresp=%b/%b want 0", s0_axil_rdata, s1_axil_rdata, s0_axil_rresp, s1_axil_rresp); end
      rst = 1'b0;
      model_last = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int got;
      pend[0] = 1'b1; s_araddr[0] = 32'h4000_0010; s_arprot[0] = 3'b010;
      do_txn(0, 0, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00, got);
      @(negedge clk);
      total++;
      if (s1_axil_rdata !== 32'h0 || s1_axil_rresp !== 2'b00 || s1_axil_rvalid !== 1'b0)
         begin bad++; $display("FAIL single_s1_quiet: rdata=%h rresp=%b rvalid=%b want 0", s1_axil_rdata, s1_axil_rresp, s1_axil_rvalid); end
      tick();
   endtask

   task automatic test_round_robin();
      int got;
      test_reset();
      post(0); post(1);
      for (int i = 0; i < 4; i++) begin
         do_txn(0, 0, 0, 0, 1'b0, 1'b1, $urandom, 2'b00, got);
         total++;
         if (got !== i % 2)
            begin bad++; $display("FAIL rr_order txn %0d: granted s%0d want s%0d", i, got, i % 2); end
      end
   endtask

   task automatic test_stall();
      int got;
      post(0); post(1);
      do_txn(5, 2, 3, 0, 1'b0, 1'b0, 32'h1234_5678, 2'b01, got);
      while (pend != 2'b00) do_txn(1, 1, 0, 0, 1'b0, 1'b0, $urandom, 2'b00, got);
   endtask

   task automatic test_timeout();
      int got;
      post(0);
      do_txn(0, 0, 0, 2, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'b00, got);
      @(negedge clk);
      total++;
      if (s0_axil_rvalid !== 1'b0 || s0_axil_rdata !== 32'h0 || s0_axil_rresp !== 2'b10 || m_axil_rready !== 1'b0)
         begin bad++; $display("FAIL timeout_after: rvalid=%b rdata=%h rresp=%b rready=%b want 0 0 10 0",
                               s0_axil_rvalid, s0_axil_rdata, s0_axil_rresp, m_axil_rready); end
      tick();
      post(1);
      do_txn(0, 3, 0, 0, 1'b0, 1'b0, 32'hCAFE_0001, 2'b00, got);
   endtask

   task automatic test_reset_mid();
      int got;
      pend = 2'b00; s_arvalid = 2'b01; s_araddr[0] = 32'h0000_ABC0; s_arprot[0] = 3'b001;
      @(negedge clk);
      total++;
      if (s0_axil_arready !== 1'b1)
         begin bad++; $display("FAIL mid_grant: arready=%b want 1", s0_axil_arready); end
      tick();
      s_arvalid = 2'b00; m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      @(negedge clk);
      total++;
      if (m_axil_rready !== 1'b1)
         begin bad++; $display("FAIL mid_in_data: rready=%b want 1", m_axil_rready); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (ardy !== 2'b00 || rv !== 2'b00 || m_axil_arvalid !== 1'b0 || m_axil_rready !== 1'b0 || m_axil_araddr !== 32'h0 || m_axil_arprot !== 3'h0)
         begin bad++; $display("FAIL mid_reset: arready=%b rvalid=%b arvalid=%b rready=%b araddr=%h arprot=%h want all 0",
                               ardy, rv, m_axil_arvalid, m_axil_rready, m_axil_araddr, m_axil_arprot); end
      model_last = 1'b1;
      tick();
      post(1);
      do_txn(0, 0, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, 2'b00, got);
      total++;
      if (got !== 1)
         begin bad++; $display("FAIL mid_s1_grant: granted s%0d want s1", got); end
   endtask

   task automatic test_random();
      int got;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) post(0);
         if ($urandom_range(0, 1) == 1) post(1);
         if (pend == 2'b00) post($urandom_range(0, 1));
         do_txn($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), $urandom, 2'($urandom), got);
      end
   endtask

   initial begin
      s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
